// File: rtl/md_sequencer_if.sv
// Issue/result bundle between the E stage and the multiply/divide sequencer.
// The E stage (master) launches ops; the sequencer (slave) reports busy, HI/LO and done.
interface md_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        Req;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        done;

  modport master (output start, op, rs, rt, Req, input busy, HI, LO, done);
  modport slave  (input start, op, rs, rt, Req, output busy, HI, LO, done);
endinterface

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: computes the result at launch, then holds busy for a
// fixed op-dependent latency before committing it to the architectural HI/LO.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  md_sequencer_if.slave md
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  typedef struct packed {
    logic        keep;  // divide by zero: commit leaves HI/LO alone
    logic [31:0] hi;
    logic [31:0] lo;
  } md_rsp_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_e      state_q, state_n;
  logic [3:0]  cnt_q, cnt_n;
  md_rsp_t     pend_q, rsp;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  md_op_e      op;
  logic        accept, launch, commit;

  logic [63:0] prod_s, prod_u;
  logic        sgn_div;
  logic [31:0] dvd, dvs, quo, rem;

  assign op     = md_op_e'(md.op);
  assign accept = md.start & ~md.Req & (state_q == S_IDLE) &
                  (op != OP_NONE) & (op != OP_RSVD);
  assign launch = accept & (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
  assign commit = (state_q == S_BUSY) & (cnt_q == 4'd1);

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
  always_comb begin
    prod_s  = $signed({{32{md.rs[31]}}, md.rs}) * $signed({{32{md.rt[31]}}, md.rt});
    prod_u  = {32'd0, md.rs} * {32'd0, md.rt};
    sgn_div = (op == OP_DIV);
    dvd     = (sgn_div & md.rs[31]) ? (~md.rs + 32'd1) : md.rs;
    dvs     = (sgn_div & md.rt[31]) ? (~md.rt + 32'd1) : md.rt;
    quo     = '0;
    rem     = '0;
    if (dvs != 32'd0) begin
      quo = dvd / dvs;
      rem = dvd % dvs;
    end
    if (sgn_div & (md.rs[31] ^ md.rt[31])) quo = ~quo + 32'd1;
    if (sgn_div & md.rs[31])               rem = ~rem + 32'd1;
  end

  always_comb begin
    rsp = '0;
    unique case (op)
      OP_MULT:         rsp = '{keep: 1'b0, hi: prod_s[63:32], lo: prod_s[31:0]};
      OP_MULTU:        rsp = '{keep: 1'b0, hi: prod_u[63:32], lo: prod_u[31:0]};
      OP_DIV, OP_DIVU: rsp = '{keep: (md.rt == 32'd0), hi: rem, lo: quo};
      default:         rsp = '0;
    endcase
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_n = S_BUSY;
          cnt_n   = (op inside {OP_MULT, OP_MULTU}) ? MULT_N : DIV_N;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd1) begin
          state_n = S_IDLE;
          cnt_n   = 4'd0;
        end else begin
          cnt_n   = cnt_q - 4'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      done_q  <= commit;
      if (launch) pend_q <= rsp;
      if (commit) begin
        if (!pend_q.keep) begin
          hi_q <= pend_q.hi;
          lo_q <= pend_q.lo;
        end
      end else if (accept && op == OP_MTHI) begin
        hi_q <= md.rs;
      end else if (accept && op == OP_MTLO) begin
        lo_q <= md.rs;
      end
    end
  end

  assign md.busy = (state_q == S_BUSY);
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;
  assign md.done = done_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboarded bench for md_sequencer: driver predicts each result from plain arithmetic,
// monitor pops on done and also tracks the architectural HI/LO every idle cycle.
module tb_md_sequencer;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_sequencer_if md();
  md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .md(md)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(int op, logic [31:0] a, logic [31:0] b);
    exp_t r;
    int sa, sbv;
    longint p;
    longint unsigned pu;
    sa   = a;
    sbv  = b;
    r.hi = m_hi;
    r.lo = m_lo;
    r.n  = (op <= 2) ? MULT_N : DIV_N;
    case (op)
      1: begin p = longint'(sa) * longint'(sbv); r.hi = p[63:32]; r.lo = p[31:0]; end
      2: begin pu = longint'(a) * longint'(b); r.hi = pu[63:32]; r.lo = pu[31:0]; end
      3: if (b != 0) begin
        if (a == 32'h8000_0000 && sbv == -1) begin r.lo = a; r.hi = 0; end
        else begin r.lo = sa / sbv; r.hi = sa % sbv; end
      end
      4: if (b != 0) begin r.lo = a / b; r.hi = a % b; end
      default: ;
    endcase
    return r;
  endfunction

  // Monitor: busy run length, result on done, and steady HI/LO while idle.
  initial begin
    exp_t e;
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (reset) run = 0;
      else if (md.done) begin
        if (q.size() == 0) chk("spurious_done", 64'(md.done), 64'd0);
        else begin
          e = q.pop_front();
          chk("done_hi", 64'(md.HI), 64'(e.hi));
          chk("done_lo", 64'(md.LO), 64'(e.lo));
          chk("busy_cycles", 64'(run), 64'(e.n));
          m_hi = e.hi;
          m_lo = e.lo;
        end
        run = 0;
      end else if (md.busy) run++;
      else begin
        chk("idle_hi", 64'(md.HI), 64'(m_hi));
        chk("idle_lo", 64'(md.LO), 64'(m_lo));
      end
    end
  end

  task automatic drive(bit s, logic [2:0] op, logic [31:0] a, logic [31:0] b, bit req);
    @(posedge clk); #1;
    md.start = s; md.op = op; md.rs = a; md.rt = b; md.Req = req;
  endtask

  task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b, bit req);
    bit acc;
    acc = !req && op >= 1 && op <= 6;
    drive(1'b1, op, a, b, req);
    if (acc && op <= 4) q.push_back(model(int'(op), a, b));
    @(posedge clk); #1;
    md.start = 1'b0; md.Req = 1'b0;
    if (acc && op == 5) m_hi = a;
    if (acc && op == 6) m_lo = a;
    if (!acc || op >= 5) chk("no_busy", 64'(md.busy), 64'd0);
    else repeat ((op <= 2 ? MULT_N : DIV_N) + 1) @(posedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] op;
    reset = 1'b1;
    md.start = 1'b0; md.op = 3'd0; md.rs = 32'd0; md.rt = 32'd0; md.Req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", 64'(md.busy), 64'd0);
    chk("rst_done", 64'(md.done), 64'd0);
    chk("rst_hi", 64'(md.HI), 64'd0);
    chk("rst_lo", 64'(md.LO), 64'd0);

    issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(3'd4, 32'd7, 32'd0, 1'b0);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(3'd1, 32'd5, 32'd6, 1'b1);
    issue(3'd5, 32'h0000_1234, 32'd0, 1'b0);
    issue(3'd6, 32'h0000_5678, 32'd0, 1'b0);
    issue(3'd0, 32'd1, 32'd1, 1'b0);
    issue(3'd7, 32'd1, 32'd1, 1'b0);

    // Reset in the third busy cycle of a div abandons it; done must not follow.
    drive(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
    @(posedge clk); #1 md.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("rstmid_busy", 64'(md.busy), 64'd0);
    chk("rstmid_hi", 64'(md.HI), 64'd0);
    chk("rstmid_lo", 64'(md.LO), 64'd0);
    repeat (DIV_N + 2) @(posedge clk);

    // Req and a stray mthi start while busy: mult still commits on schedule.
    drive(1'b1, 3'd1, 32'd3, 32'd4, 1'b0);
    q.push_back(model(1, 32'd3, 32'd4));
    @(posedge clk); #1;
    md.start = 1'b1; md.op = 3'd5; md.rs = 32'hDEAD; md.Req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 md.start = 1'b0; md.Req = 1'b0;
    repeat (MULT_N) @(posedge clk);

    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      issue(op, pick(), pick(), ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
